// File: rtl/debounce_multi_ch_if.sv
// Pin/event bundle for the multi-channel button conditioner.
// master drives the raw pins and consumes events; slave is the conditioner.
interface debounce_multi_ch_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] btn_raw;
    logic [CHANNELS-1:0] btn_state;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] long_pulse;
    logic [CHANNELS-1:0] repeat_pulse;
    logic                any_event;

    modport master (
        output btn_raw,
        input  btn_state,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  any_event
    );

    modport slave (
        input  btn_raw,
        output btn_state,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output any_event
    );
endinterface

// File: rtl/debounce_multi_ch.sv
// N-channel push-button conditioner: sync, polarity fix, tick-based debounce,
// press/release/long-press/auto-repeat events on a shared tick prescaler.
//
// Hold FSM, one per channel:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | button released; hold/repeat counters parked at zero
//   ST_HELD | accepted press, counting ticks towards long_pulse
//   ST_LONG | long press reached; counting repeat period (or parked if off)
module debounce_multi_ch #(
    parameter int unsigned         CLK_FREQ_HZ     = 10_000_000,
    parameter int unsigned         CHANNELS        = 4,
    parameter int unsigned         TICK_HZ         = 10_000,
    parameter int unsigned         DEB_TICKS       = 5,
    parameter int unsigned         LONG_TICKS      = 10_000,
    parameter int unsigned         REPEAT_TICKS    = 0,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    debounce_multi_ch_if.slave bus
);
    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEB_TICKS + 1);
    localparam int unsigned LW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
    localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_TICKS - 1);
    localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_e;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    logic [CHANNELS-1:0] state_v;
    logic [CHANNELS-1:0] press_v;
    logic [CHANNELS-1:0] release_v;
    logic [CHANNELS-1:0] long_v;
    logic [CHANNELS-1:0] repeat_v;
    logic [CHANNELS-1:0] event_d;
    logic                any_event_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          s0_q, s1_q;
        logic          lvl;
        logic          state_q, state_d;
        logic [DW-1:0] deb_q, deb_d;
        logic [LW-1:0] hold_q, hold_d;
        logic [RW-1:0] rep_q, rep_d;
        hold_state_e   fsm_q, fsm_d;
        logic          acc_press, acc_release;
        logic          long_now, repeat_now;
        logic          press_q, release_q, long_q, repeat_q;

        assign lvl = s1_q ^ ACTIVE_LOW_MASK[i];

        // A change is accepted only after DEB_TICKS ticks with no glitch back.
        always_comb begin
            deb_d       = deb_q;
            state_d     = state_q;
            acc_press   = 1'b0;
            acc_release = 1'b0;
            if (lvl == state_q) begin
                deb_d = '0;
            end else if (tick) begin
                if (deb_q == DEB_LAST) begin
                    state_d     = lvl;
                    deb_d       = '0;
                    acc_press   = lvl;
                    acc_release = ~lvl;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
        end

        // Release is checked first so it always beats a coincident long/repeat tick.
        always_comb begin
            fsm_d      = fsm_q;
            hold_d     = hold_q;
            rep_d      = rep_q;
            long_now   = 1'b0;
            repeat_now = 1'b0;
            unique case (fsm_q)
                ST_IDLE: begin
                    hold_d = '0;
                    rep_d  = '0;
                    if (acc_press) begin
                        fsm_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (acc_release) begin
                        fsm_d  = ST_IDLE;
                        hold_d = '0;
                        rep_d  = '0;
                    end else if (tick) begin
                        if (hold_q == LONG_LAST) begin
                            long_now = 1'b1;
                            fsm_d    = ST_LONG;
                            hold_d   = '0;
                            rep_d    = '0;
                        end else begin
                            hold_d = hold_q + LW'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (acc_release) begin
                        fsm_d  = ST_IDLE;
                        hold_d = '0;
                        rep_d  = '0;
                    end else if ((REPEAT_TICKS != 0) && tick) begin
                        if (rep_q == REP_LAST) begin
                            repeat_now = 1'b1;
                            rep_d      = '0;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
                    end
                end
                default: begin
                    fsm_d  = ST_IDLE;
                    hold_d = '0;
                    rep_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s0_q      <= ACTIVE_LOW_MASK[i];
                s1_q      <= ACTIVE_LOW_MASK[i];
                state_q   <= 1'b0;
                deb_q     <= '0;
                hold_q    <= '0;
                rep_q     <= '0;
                fsm_q     <= ST_IDLE;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                s0_q      <= bus.btn_raw[i];
                s1_q      <= s0_q;
                state_q   <= state_d;
                deb_q     <= deb_d;
                hold_q    <= hold_d;
                rep_q     <= rep_d;
                fsm_q     <= fsm_d;
                press_q   <= acc_press;
                release_q <= acc_release;
                long_q    <= long_now;
                repeat_q  <= repeat_now;
            end
        end

        assign state_v[i]   = state_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
        assign long_v[i]    = long_q;
        assign repeat_v[i]  = repeat_q;
        assign event_d[i]   = acc_press | acc_release | long_now | repeat_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_event_q <= 1'b0;
        end else begin
            any_event_q <= |event_d;
        end
    end

    assign bus.btn_state     = state_v;
    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.long_pulse    = long_v;
    assign bus.repeat_pulse  = repeat_v;
    assign bus.any_event     = any_event_q;
endmodule

// File: tb/tb_debounce_multi_ch.sv
// Scoreboard bench for debounce_multi_ch: timestamp-based reference model
// predicts every event edge; a negedge monitor pops and compares.
module tb_debounce_multi_ch;
    localparam int          CH    = 4;
    localparam int          TDIV  = 4;
    localparam int          DEB   = 3;
    localparam int          LONGT = 8;
    localparam int          REPT  = 4;
    localparam logic [3:0]  MASK  = 4'b0010;

    typedef struct {
        int         stamp;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic [3:0] rp;
    } ev_t;

    logic       clk;
    logic       rst;
    logic [3:0] raw;

    debounce_multi_ch_if #(.CHANNELS(CH)) bus ();
    assign bus.btn_raw = raw;

    debounce_multi_ch #(
        .CLK_FREQ_HZ(1000), .CHANNELS(CH), .TICK_HZ(250), .DEB_TICKS(DEB),
        .LONG_TICKS(LONGT), .REPEAT_TICKS(REPT), .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    ev_t        q[$];
    int         g = 0;
    bit         model_on = 0;
    int         n;
    logic [3:0] r0, r1, lvl, m_state, pr, rl, lg, rp;
    int         dstart[CH];
    int         pn[CH];
    int         dt;
    bit         tck;

    initial begin
        m_state = '0;
        forever begin
            @(posedge clk);
            g++;
            if (rst) begin
                model_on = 1;
                n        = 0;
                r0       = MASK;
                r1       = MASK;
                m_state  = '0;
                for (int i = 0; i < CH; i++) begin
                    dstart[i] = -1;
                    pn[i]     = -1;
                end
            end else if (model_on) begin
                n++;
                tck = (n % TDIV == 0);
                lvl = r1 ^ MASK;
                r1  = r0;
                r0  = raw;
                pr = '0; rl = '0; lg = '0; rp = '0;
                for (int i = 0; i < CH; i++) begin
                    if (lvl[i] == m_state[i]) begin
                        dstart[i] = -1;
                    end else begin
                        if (dstart[i] < 0) dstart[i] = n;
                        // ticks seen in [dstart, n] while the level stayed different
                        if (tck && (n / TDIV - (dstart[i] - 1) / TDIV) == DEB) begin
                            m_state[i] = lvl[i];
                            dstart[i]  = -1;
                            if (lvl[i]) begin
                                pr[i] = 1'b1;
                                pn[i] = n;
                            end else begin
                                rl[i] = 1'b1;
                                pn[i] = -1;
                            end
                        end
                    end
                    if (m_state[i] && !pr[i] && pn[i] >= 0) begin
                        dt = n - pn[i];
                        if (dt == LONGT * TDIV) lg[i] = 1'b1;
                        else if (dt > LONGT * TDIV && ((dt - LONGT * TDIV) % (REPT * TDIV)) == 0)
                            rp[i] = 1'b1;
                    end
                end
                if ((pr | rl | lg | rp) != 0) q.push_back('{g, pr, rl, lg, rp});
            end
        end
    end

    // ---------------- monitor ----------------
    int  cnt_press[CH], cnt_rel[CH], cnt_long[CH], cnt_rep[CH];
    int  press_stamp[CH], rel_stamp[CH], lr_stamp[CH];
    int  cnt_total = 0;
    int  cnt_dual  = 0;
    ev_t e;
    bit  dut_any;

    initial begin
        for (int i = 0; i < CH; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0; cnt_rep[i] = 0;
            press_stamp[i] = -1000; rel_stamp[i] = -1000; lr_stamp[i] = -1000;
        end
        forever begin
            @(negedge clk);
            if (model_on) begin
                checks++;
                if (bus.btn_state !== m_state) begin
                    errors++;
                    $display("FAIL btn_state @%0d: got %b want %b", g, bus.btn_state, m_state);
                end
                dut_any = ((bus.press_pulse | bus.release_pulse | bus.long_pulse |
                            bus.repeat_pulse) != 0) || bus.any_event;
                if (dut_any) begin
                    cnt_total++;
                    if (bus.press_pulse[0] && bus.press_pulse[3]) cnt_dual++;
                    for (int i = 0; i < CH; i++) begin
                        if (bus.press_pulse[i]) begin
                            cnt_press[i]++;
                            press_stamp[i] = g;
                        end
                        if (bus.release_pulse[i]) begin
                            cnt_rel[i]++;
                            rel_stamp[i] = g;
                        end
                        if (bus.long_pulse[i]) begin
                            cnt_long[i]++;
                            checks++;
                            if (g - press_stamp[i] != LONGT * TDIV) begin
                                errors++;
                                $display("FAIL long_delay ch%0d: got %0d want %0d", i,
                                         g - press_stamp[i], LONGT * TDIV);
                            end
                            lr_stamp[i] = g;
                        end
                        if (bus.repeat_pulse[i]) begin
                            cnt_rep[i]++;
                            checks++;
                            if (g - lr_stamp[i] != REPT * TDIV) begin
                                errors++;
                                $display("FAIL repeat_gap ch%0d: got %0d want %0d", i,
                                         g - lr_stamp[i], REPT * TDIV);
                            end
                            lr_stamp[i] = g;
                        end
                    end
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event @%0d: pr=%b rl=%b lg=%b rp=%b any=%b",
                                 g, bus.press_pulse, bus.release_pulse, bus.long_pulse,
                                 bus.repeat_pulse, bus.any_event);
                    end else begin
                        e = q.pop_front();
                        if (e.stamp != g || bus.press_pulse !== e.pr || bus.release_pulse !== e.rl ||
                            bus.long_pulse !== e.lg || bus.repeat_pulse !== e.rp ||
                            bus.any_event !== 1'b1) begin
                            errors++;
                            $display("FAIL event @%0d: got pr=%b rl=%b lg=%b rp=%b any=%b want @%0d pr=%b rl=%b lg=%b rp=%b any=1",
                                     g, bus.press_pulse, bus.release_pulse, bus.long_pulse,
                                     bus.repeat_pulse, bus.any_event, e.stamp, e.pr, e.rl, e.lg, e.rp);
                        end
                    end
                end else if (q.size() > 0 && q[0].stamp <= g) begin
                    checks++;
                    errors++;
                    e = q.pop_front();
                    $display("FAIL missed_event @%0d: got none want pr=%b rl=%b lg=%b rp=%b",
                             e.stamp, e.pr, e.rl, e.lg, e.rp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_int(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    int g0, base_p, base_r, base_l, lim;
    int chn;

    initial begin
        rst = 1'b1;
        raw = 4'b0010;
        cycles(3);
        rst = 1'b0;
        check_int("reset_state", int'(bus.btn_state), 0, 0);
        cycles(50);
        check_int("reset_quiet", cnt_total, 0, 0);

        // clean press and release on ch0
        g0 = g; raw[0] = 1'b1;
        cycles(16);
        check_int("ch0_press_count", cnt_press[0], 1, 1);
        check_int("ch0_press_latency", press_stamp[0] - g0, 11, 14);
        g0 = g; raw[0] = 1'b0;
        cycles(16);
        check_int("ch0_release_count", cnt_rel[0], 1, 1);
        check_int("ch0_release_latency", rel_stamp[0] - g0, 11, 14);

        // bounce on ch2
        for (int k = 0; k < 12; k++) begin
            raw[2] = ~raw[2];
            cycles(5);
        end
        check_int("ch2_bounce_quiet", cnt_press[2] + cnt_rel[2], 0, 0);
        raw[2] = 1'b1;
        cycles(20);
        check_int("ch2_settle_press", cnt_press[2], 1, 1);
        raw[2] = 1'b0;
        cycles(20);

        // active-low ch1
        raw[1] = 1'b0;
        cycles(20);
        check_int("ch1_press", cnt_press[1], 1, 1);
        check_int("ch1_state", int'(bus.btn_state[1]), 1, 1);
        raw[1] = 1'b1;
        cycles(20);

        // long press + repeat on ch3
        raw[3] = 1'b1;
        cycles(200);
        check_int("ch3_long", cnt_long[3], 1, 1);
        check_int("ch3_repeats", cnt_rep[3], 8, 10);
        raw[3] = 1'b0;
        cycles(20);
        check_int("ch3_release", cnt_rel[3], 1, 1);

        // simultaneous press, then reset while ch0 is in long-press
        base_l = cnt_long[0];
        raw[0] = 1'b1; raw[3] = 1'b1;
        cycles(20);
        check_int("dual_press", cnt_dual, 1, 1);
        cycles(40);
        check_int("ch0_long_before_rst", cnt_long[0] - base_l, 1, 1);
        base_r = cnt_rel[0];
        rst = 1'b1; raw = 4'b0010;
        cycles(1);
        check_int("rst_outputs_zero",
                  int'({bus.btn_state, bus.press_pulse, bus.release_pulse,
                        bus.long_pulse, bus.repeat_pulse, bus.any_event}), 0, 0);
        rst = 1'b0;
        cycles(30);
        check_int("no_release_after_rst", cnt_rel[0] - base_r, 0, 0);

        // randomized traffic, varying bounce density
        base_p = cnt_total;
        for (int seg = 0; seg < 12; seg++) begin
            lim = $urandom_range(2, 40);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if ($urandom_range(0, lim) == 0) begin
                    chn = $urandom_range(0, CH - 1);
                    raw[chn] = ~raw[chn];
                end
            end
        end
        check_int("random_activity", (cnt_total > base_p) ? 1 : 0, 1, 1);
        cycles(40);
        check_int("queue_drained", q.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
